// File: rtl/ysyx_24090003_mem_arbiter.sv
// Arbitrates IFU and LSU requests onto one memory port, one transaction at a time (LSU has priority).
// Latency: accept N, mem request N+1, owner response no earlier than N+3; a timeout forces an error response.
module ysyx_24090003_mem_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ifu_req_valid,
  output logic        o_ifu_req_ready,
  input  logic [31:0] i_ifu_addr,
  output logic        o_ifu_resp_valid,
  output logic [31:0] o_ifu_rdata,
  output logic        o_ifu_resp_err,
  input  logic        i_lsu_req_valid,
  output logic        o_lsu_req_ready,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_lsu_wmask,
  output logic        o_lsu_resp_valid,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_resp_err,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic [2:0]  o_mem_wmask,
  input  logic        i_mem_resp_valid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1: LSU, 0: IFU
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        timeout;

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  // Fires in the cycle whose increment makes the counter equal TIMEOUT.
  assign timeout = ({1'b0, cnt_q} + 9'd1) >= TimeoutLim;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    we_d            = we_q;
    wmask_d         = wmask_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    cnt_d           = cnt_q;
    o_ifu_req_ready = 1'b0;
    o_lsu_req_ready = 1'b0;
    o_mem_req_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_lsu_req_ready = 1'b1;
        o_ifu_req_ready = ~i_lsu_req_valid;
        if (i_lsu_req_valid) begin
          owner_d = 1'b1;
          addr_d  = i_lsu_addr;
          wdata_d = i_lsu_wdata;
          we_d    = i_lsu_we;
          wmask_d = i_lsu_wmask;
          cnt_d   = 8'd0;
          state_d = S_REQ;
        end else if (i_ifu_req_valid) begin
          owner_d = 1'b0;
          addr_d  = i_ifu_addr;
          wdata_d = 32'd0;
          we_d    = 1'b0;
          wmask_d = 3'd0;
          cnt_d   = 8'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        o_mem_req_valid = 1'b1;
        cnt_d           = cnt_inc;
        if (timeout) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (i_mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // A real response arriving on the timeout cycle takes precedence.
        if (i_mem_resp_valid) begin
          rdata_d = i_mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      wmask_q <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_mem_addr       = (state_q == S_REQ) ? addr_q  : 32'd0;
  assign o_mem_wdata      = (state_q == S_REQ) ? wdata_q : 32'd0;
  assign o_mem_we         = (state_q == S_REQ) & we_q;
  assign o_mem_wmask      = (state_q == S_REQ) ? wmask_q : 3'd0;

  assign o_ifu_resp_valid = (state_q == S_RESP) & ~owner_q;
  assign o_ifu_rdata      = o_ifu_resp_valid ? rdata_q : 32'd0;
  assign o_ifu_resp_err   = o_ifu_resp_valid & err_q;
  assign o_lsu_resp_valid = (state_q == S_RESP) & owner_q;
  assign o_lsu_rdata      = o_lsu_resp_valid ? rdata_q : 32'd0;
  assign o_lsu_resp_err   = o_lsu_resp_valid & err_q;

  assign o_busy           = (state_q != S_IDLE);

endmodule

// File: doc/ysyx_24090003_mem_arbiter.md
YSYX_24090003_MEM_ARBITER -- requirements
Module: ysyx_24090003_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles from entering REQ to a memory response before an error response is forced.
REQ-002 Parameter ERR_RDATA, default 32'h0000_0000: rdata returned with an error response.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_ifu_req_valid  in  1;  o_ifu_req_ready  out  1;  i_ifu_addr  in  32  IFU read request (read only).
REQ-006 o_ifu_resp_valid  out  1;  o_ifu_rdata  out  32;  o_ifu_resp_err  out  1  IFU response.
REQ-007 i_lsu_req_valid  in  1;  o_lsu_req_ready  out  1;  i_lsu_addr  in  32;  i_lsu_wdata  in  32;  i_lsu_we  in  1;  i_lsu_wmask  in  3  LSU request.
REQ-008 o_lsu_resp_valid  out  1;  o_lsu_rdata  out  32;  o_lsu_resp_err  out  1  LSU response.
REQ-009 o_mem_req_valid  out  1;  i_mem_req_ready  in  1;  o_mem_addr  out  32;  o_mem_wdata  out  32;  o_mem_we  out  1;  o_mem_wmask  out  3  shared memory request.
REQ-010 i_mem_resp_valid  in  1;  i_mem_rdata  in  32  shared memory response.
REQ-011 o_busy  out  1  high in every state except IDLE.

Function
REQ-012 FSM states IDLE, REQ, WAIT, RESP; single outstanding transaction.
REQ-013 IDLE: o_lsu_req_ready=1; o_ifu_req_ready = ~i_lsu_req_valid; all other request/response outputs 0.
REQ-014 Handshake: a request is accepted on a cycle where valid & ready are both high; LSU has fixed priority when both valid in the same cycle.
REQ-015 On acceptance: register addr, wdata, we, wmask (IFU: wdata=0, we=0, wmask=0) and owner (IFU/LSU); next state REQ.
REQ-016 REQ: o_mem_req_valid=1 with registered fields stable; on i_mem_req_ready=1 go to WAIT.
REQ-017 WAIT: o_mem_req_valid=0; on i_mem_resp_valid=1 capture i_mem_rdata, err=0, go to RESP.
REQ-018 i_mem_resp_valid outside WAIT is ignored (no state or data change).
REQ-019 RESP: owner's resp_valid=1 for exactly one cycle with captured rdata/err; non-owner resp outputs 0; next state IDLE; both req_ready 0.
REQ-020 Writes (we=1) also produce one response cycle; rdata is whatever memory returned.
REQ-021 Minimum latency: accept at cycle N, mem_req_valid N+1, with ready at N+1 and resp_valid at N+2, owner resp_valid at N+3.
REQ-022 Timeout counter: cleared on acceptance, increments each cycle in REQ and WAIT; when it reaches TIMEOUT without a response, go to RESP with err=1, rdata=ERR_RDATA; o_mem_req_valid drops to 0.
REQ-023 Counter width 8 bits for TIMEOUT ≤255; saturates, never wraps.
REQ-024 i_mem_resp_valid in the same cycle the counter reaches TIMEOUT: the real response wins (err=0).
REQ-025 Request inputs changing after acceptance have no effect on the current transaction.

Reset
REQ-026 Reset asserted at any time (including mid-transaction) forces IDLE immediately; counter, captured fields and owner cleared to 0; in-flight transaction dropped with no response.
REQ-027 During reset all outputs are 0 except o_lsu_req_ready and o_ifu_req_ready, which follow REQ-013 combinationally from IDLE; o_busy=0.
REQ-028 First acceptance possible on the first rising edge after i_rst_n deasserts.

Verification
REQ-029 IFU read addr 0x8000_0000, mem ready immediately, resp 1 cycle later with 0x0000_0413 -> o_ifu_resp_valid one cycle, rdata 0x0000_0413, err 0, 3-cycle latency.
REQ-030 IFU and LSU valid same cycle (LSU write 0x8000_1000, data 0xCAFE_F00D, wmask 3'b010) -> LSU served first, mem sees we=1 with those values; IFU accepted in next IDLE.
REQ-031 Mem holds i_mem_req_ready=0 for 5 cycles -> o_mem_req_valid held high, address stable all 5 cycles.
REQ-032 TIMEOUT=8, memory never responds -> after 8 cycles owner resp_valid=1, err=1, rdata=ERR_RDATA, then IDLE.
REQ-033 Reset asserted in WAIT, then spurious i_mem_resp_valid after reset release -> no response output, state IDLE, o_busy=0.
REQ-034 Response coincident with timeout cycle (TIMEOUT=4, resp on 4th cycle, data 0x1234_5678) -> err=0, rdata 0x1234_5678.
